// File: rtl/data_memory_banked.sv
// data_memory_banked: byte-lane data memory with registered read and clear sweep.
// Define DMEM_BYPASS_EN to build the one-entry write-forwarding variant.
module data_memory_banked #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);
    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = ADDR_W - LSB;
    localparam int MW    = $clog2(DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [MW-1:0]     sweep_cnt;
    logic              sweep_last;
    logic              clr_we;

    logic [IDX_W-1:0]  idx;
    logic [MW-1:0]     widx;
    logic              misalign;
    logic              oor;
    logic              err;
    logic              acc;
    logic              wr_ok;
    logic              rd_ok;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_raw;
    logic              rd_q;

    assign idx      = req_addr[ADDR_W-1:LSB];
    assign widx     = idx[MW-1:0];
    assign misalign = |req_addr[LSB-1:0];
    assign oor      = (int'(idx) >= DEPTH);
    assign err      = misalign || oor;

    // rst wins over a same-cycle handshake: nothing is written or answered
    assign acc   = req_valid && req_ready && !rst;
    assign wr_ok = acc && req_we && !err;
    assign rd_ok = acc && !req_we && !err;

    assign sweep_last = (sweep_cnt == MW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR: begin
                if (!clr && sweep_last) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        req_ready = 1'b0;
        clr_we    = 1'b0;
        unique case (state_q)
            CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
            end
            RUN: begin
                req_ready = !clr;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr || state_q != CLEAR || sweep_last) begin
            sweep_cnt <= '0;
        end else begin
            sweep_cnt <= sweep_cnt + 1'b1;
        end
    end

`ifdef DMEM_BYPASS_EN
    logic              fwd_v;
    logic [MW-1:0]     fwd_idx;
    logic [DATA_W-1:0] fwd_data;
    logic [NB-1:0]     fwd_be;
    logic              fwd_hit;

    assign fwd_hit = fwd_v && (fwd_idx == widx);

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_v <= 1'b0;
        end else begin
            fwd_v <= wr_ok;
        end
        if (wr_ok) begin
            fwd_idx  <= widx;
            fwd_data <= req_wdata;
            fwd_be   <= req_be;
        end
    end

    // Array commits a write one edge late; reads merge the pending lanes
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[sweep_cnt] <= '0;
        end else if (fwd_v) begin
            for (int k = 0; k < NB; k++) begin
                if (fwd_be[k]) begin
                    mem[fwd_idx][8*k +: 8] <= fwd_data[8*k +: 8];
                end
            end
        end
        if (rd_ok) begin
            for (int k = 0; k < NB; k++) begin
                rd_raw[8*k +: 8] <= (fwd_hit && fwd_be[k]) ?
                    fwd_data[8*k +: 8] : mem[widx][8*k +: 8];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[sweep_cnt] <= '0;
        end else if (wr_ok) begin
            for (int k = 0; k < NB; k++) begin
                if (req_be[k]) begin
                    mem[widx][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
        if (rd_ok) begin
            rd_raw <= mem[widx];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            rsp_valid <= acc;
            rsp_err   <= acc && err;
            rd_q      <= rd_ok;
        end
    end

    assign rsp_rdata = rd_q ? rd_raw : '0;

endmodule

// File: tb/tb_data_memory_banked.sv
// tb_data_memory_banked: directed and random requests against a behavioural model.
// Two instances: DEPTH=256 (full range) and DEPTH=200 (out-of-range indices).
module tb_data_memory_banked;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;

    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;
    logic        s_req_ready, s_rsp_valid, s_rsp_err, s_busy;
    logic [15:0] s_rsp_rdata;

    int vectors = 0;
    int miscompares = 0;

    bit [15:0] ref_mem [256];
    int        m_left = 0;
    int        s_left = 0;
    bit        known = 1'b0;

    always #5 clk = ~clk;

    data_memory_banked u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    data_memory_banked #(.DEPTH(200)) u_small (
        .clk(clk), .rst(rst), .clr(clr),
        .req_valid(req_valid), .req_ready(s_req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata),
        .rsp_err(s_rsp_err), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; expectations come from the memory rules alone
    task automatic step(input logic v, input logic we, input logic [8:0] a,
                        input logic [15:0] wd, input logic [1:0] be,
                        input logic c, input logic r);
        bit        rdy_m, rdy_s, acc_m, acc_s, err_m, err_s, post;
        bit [15:0] exp_m, exp_s;
        int        idx;
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a;
        req_wdata = wd; req_be = be; clr = c; rst = r;
        #1;
        idx   = int'(a) / 2;
        rdy_m = (m_left == 0) && !c;
        rdy_s = (s_left == 0) && !c;
        if (known) begin
            chk("ready", req_ready, rdy_m);
            chk("s_ready", s_req_ready, rdy_s);
        end
        acc_m = known && v && rdy_m && !r;
        acc_s = known && v && rdy_s && !r;
        err_m = a[0] || idx >= 256;
        err_s = a[0] || idx >= 200;
        exp_m = (acc_m && !we && !err_m) ? ref_mem[idx] : 16'h0;
        exp_s = (acc_s && !we && !err_s) ? ref_mem[idx] : 16'h0;
        if (acc_m && we && !err_m) begin
            if (be[0]) ref_mem[idx][7:0]  = wd[7:0];
            if (be[1]) ref_mem[idx][15:8] = wd[15:8];
        end
        post = known || r;
        if (r || c) begin
            foreach (ref_mem[i]) ref_mem[i] = 16'h0;
            m_left = 256;
            s_left = 200;
            known  = 1'b1;
        end else begin
            if (m_left > 0) m_left--;
            if (s_left > 0) s_left--;
        end
        @(posedge clk);
        #1;
        if (post) begin
            chk("rsp_valid", rsp_valid, acc_m);
            chk("rsp_err", rsp_err, acc_m && err_m);
            chk("rsp_rdata", rsp_rdata, exp_m);
            chk("busy", busy, m_left > 0);
            chk("s_rsp_valid", s_rsp_valid, acc_s);
            chk("s_rsp_err", s_rsp_err, acc_s && err_s);
            chk("s_rsp_rdata", s_rsp_rdata, exp_s);
            chk("s_busy", s_busy, s_left > 0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 9'h0, 16'h0, 2'b00, 0, 0);
    endtask

    task automatic wr(input logic [8:0] a, input logic [15:0] d,
                      input logic [1:0] be);
        step(1, 1, a, d, be, 0, 0);
    endtask

    task automatic rd(input logic [8:0] a);
        step(1, 0, a, 16'h0, 2'b00, 0, 0);
    endtask

    initial begin
        logic [8:0] a;
        step(0, 0, 9'h0, 16'h0, 2'b00, 0, 1);
        step(0, 0, 9'h0, 16'h0, 2'b00, 0, 1);
        idle(256);
        for (int i = 0; i < 256; i++) rd(9'(i * 2));

        wr(9'h010, 16'hBEEF, 2'b11);
        wr(9'h010, 16'h12AB, 2'b10);
        rd(9'h010);
        chk("strobe_merge", rsp_rdata, 16'h12EF);

        wr(9'h020, 16'h3C3C, 2'b11);
        wr(9'h021, 16'hAAAA, 2'b11);
        chk("misalign_err", rsp_err, 1'b1);
        rd(9'h020);
        wr(9'h020, 16'hFFFF, 2'b00);
        rd(9'h020);
        chk("be_zero_keep", rsp_rdata, 16'h3C3C);

        wr(9'h18E, 16'hC0DE, 2'b11);
        rd(9'h190);
        chk("small_oor_err", s_rsp_err, 1'b1);
        rd(9'h18E);
        chk("small_idx199", s_rsp_rdata, 16'hC0DE);

        wr(9'h0FE, 16'h1234, 2'b11);
        rd(9'h0FE);
        chk("b2b_read", rsp_rdata, 16'h1234);
        step(1, 0, 9'h0FE, 16'h0, 2'b00, 0, 1);
        idle(256);
        rd(9'h0FE);

        wr(9'h002, 16'h5555, 2'b11);
        step(1, 0, 9'h002, 16'h0, 2'b00, 1, 0);
        idle(256);
        rd(9'h002);

        for (int i = 0; i < 400; i++) begin
            a = 9'($urandom);
            if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
            step($urandom_range(0, 3) != 0, 1'($urandom), a,
                 16'($urandom), 2'($urandom), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
